// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud-divider helper (TX and RX paths).
// Rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  function automatic int clks_per_bit(input real clk_f, input real baud);
    return $rtoi(clk_f / baud);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: byte handshake, serial line and status bundle of the UART frame transmitter.
// Rev 1.0
`default_nettype none

interface uart_frame_tx_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_tx_serial;
  logic       o_busy;
  logic       o_done;
  logic [2:0] uart_tx_state;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_tx_serial, o_busy, o_done, uart_tx_state
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_tx_serial, o_busy, o_done, uart_tx_state
  );
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: restartable bit-period counter; o_tick marks the last cycle of a bit.
// Rev 1.0
`default_nettype none

module uart_bit_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_restart,
  input  logic [CNT_W-1:0] i_load_len,
  output logic             o_tick
);

  logic [CNT_W-1:0] count;

  assign o_tick = (count == i_load_len);

  // Restarting on every tick keeps each bit exactly one period long with no carry.
  always_ff @(posedge clk) begin
    if (rst || i_restart || o_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: UART frame serialiser (start, 8 data LSB-first, optional parity, 1/2 stop).
// Rev 1.0 -- define UART_TX_PARITY_EN to insert the parity bit.
`default_nettype none

module uart_frame_tx
  import uart_pkg::*;
#(
  parameter real CLK_F      = 50_000_000.0,
  parameter real BAUD       = 9600.0,
  parameter int  STOP_BITS  = 1,
  parameter bit  PARITY_ODD = 1'b0
) (
  input logic             clk,
  input logic             rst,
  uart_frame_tx_if.slave  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_F, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_frame_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0] state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       tx;
  logic       busy;
  logic       done;
  logic       tick;

  uart_bit_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_restart  (state == S_IDLE),
    .i_load_len (CNT_W'(CLKS_PER_BIT - 1)),
    .o_tick     (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  // Parity is taken from the byte at acceptance since the shift register is consumed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.i_valid) begin
      par_bit <= (^bus.i_data) ^ PARITY_ODD;
    end
  end
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (bus.i_valid) begin
            shift <= bus.i_data;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= par_bit;
`else
              state   <= S_STOP;
              tx      <= 1'b1;
              bit_idx <= '0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            state   <= S_STOP;
            tx      <= 1'b1;
            bit_idx <= '0;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready       = (state == S_IDLE) && !rst;
  assign bus.o_tx_serial   = tx;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.uart_tx_state = state;

endmodule

`default_nettype wire

// File: doc/uart_frame_tx.md
# uart_frame_tx

Synthesizable UART frame transmitter: accepts one byte per valid/ready handshake and serialises it on a single line as start bit, 8 data bits LSB-first, optional parity and stop bit(s), with exact per-bit cycle timing derived from CLK_F/BAUD. It is the driving end of the link that the UART receive path consumes. It serves both as the TX engine behind the TX FIFO and as a synthesizable stimulus source for on-board loopback of the RX path.

## Interface
- CLK_F, 50_000_000 (real): clock frequency in Hz.
- BAUD, 9600 (real): line rate; CLKS_PER_BIT = $rtoi(CLK_F/BAUD), which is 5208 at the defaults.
- STOP_BITS, 1: number of stop bits, 1 or 2; other values are an elaboration error.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; meaningful only with UART_TX_PARITY_EN.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  byte offered.
- i_data  in  8  byte to send.
- o_ready  out  1  high only in IDLE; a transfer occurs when i_valid && o_ready on a rising edge.
- o_tx_serial  out  1  registered serial line; idle high.
- o_busy  out  1  high from the cycle after acceptance until the end of the frame.
- o_done  out  1  one-cycle pulse when a frame completes.
- uart_tx_state  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: line high, o_ready=1. On acceptance, latch i_data into a shift register and go to START. Later changes on i_data have no effect.
- START: line 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: line = shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After index 7 go to PARITY if UART_TX_PARITY_EN is defined, otherwise to STOP.
- PARITY: line = ^data ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- o_done=1 in the first IDLE cycle after STOP only.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It restarts at 0 on every state entry and every bit boundary, so there is no drift and no wrap-around carry.
- Bit index: 3 bits; it saturates by state transition and never wraps.
- i_valid while o_ready=0 is ignored. No data is lost, because the source must hold i_valid until the handshake.
- Reset values: state IDLE, o_tx_serial=1, o_busy=0, o_done=0, uart_tx_state=0. o_ready=0 while rst is high and 1 from the first cycle after release.
- Reset mid-frame: the line returns to 1 on the next edge and the frame is abandoned with no o_done.
- rst and i_valid in the same cycle: rst wins and the byte is not accepted.

## Timing
- Acceptance at edge N: o_tx_serial=0 and o_busy=1 from edge N+1.
- Frame length, 8N1: 10*CLKS_PER_BIT cycles. Add CLKS_PER_BIT with parity and CLKS_PER_BIT with STOP_BITS=2.
- o_done asserts at edge N+1+frame_length, in the same cycle that o_ready returns to 1.
- Back-to-back with i_valid held: the next byte is accepted in that IDLE cycle. Its start bit begins one cycle later, giving exactly one extra idle-high clock between frames.

## Configuration
- UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP and PARITY_ODD is honoured.
- UART_TX_PARITY_EN undefined: no parity logic is built, encoding 3 is unreachable, PARITY_ODD is ignored, and the frame is 8N1/8N2.

## Structure
- Shared package uart_pkg: typedef enum logic [2:0] uart_tx_state_t (IDLE..STOP), and a function clks_per_bit(real clk_f, real baud) shared with the RX path.
- One sub-module, uart_bit_timer: a restartable counter with inputs i_restart and i_load_len and output o_tick. This module owns the state machine, shift register and parity.

## Test plan
- Reset: hold rst for 3 cycles with i_valid=1 -> o_tx_serial=1, o_ready=0, no acceptance; after release o_ready=1 and state=0.
- Send 0x55 (8N1, 5208 cycles/bit) -> line low for 5208 cycles, then 1,0,1,0,1,0,1,0 at 5208 cycles each, then high; o_done pulses exactly 52081 cycles after the acceptance edge.
- Back-to-back 0x00 then 0xFF with i_valid held -> the second start bit falls exactly 52082 cycles after the first acceptance edge; a sampling monitor decodes 00, FF with stop bits high.
- i_data changed to 0xAA and i_valid pulsed during an 0x3C frame -> line still carries 0x3C; 0xAA is not accepted until o_ready returns.
- rst pulse during data bit 3 -> line high on the next cycle, no o_done, o_ready=1 after release; a new 0x33 frame is then correct.
- With UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame length 57288 cycles.
